// File: rtl/pending_encoder_8to3.sv
`default_nettype none
// ============================================================================
//  Module   : pending_encoder_8to3
//  Purpose  : Sequential 8-to-3 priority encoder (the encode direction of a
//             3-to-8 decoder). Request lines are accumulated into a pending
//             mask. The index of the highest-priority pending bit (bit 0
//             highest) is presented on out with a valid/ack handshake. When
//             the index is consumed, its pending bit is cleared.
//  Ports    : clk      - rising-edge clock
//             rst_n    - synchronous reset, active low
//             en       - capture enable for req
//             req[7:0] - request lines, bit i requests index i
//             ack      - consumer accepts out (ignored while valid=0)
//             out[2:0] - presented index
//             valid    - out holds a pending index
//             pending  - registered pending mask
//             count    - number of set bits in pending
//             overflow - sticky: request hit an already-pending bit
//  Revision : 1.0 - initial release
// ============================================================================
module pending_encoder_8to3 #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [W-1:0]  out,
  output logic          valid,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] count,
  output logic          overflow
);

  // Index of the lowest set bit (highest priority); zero for an empty mask.
  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] m);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(m[i]);
    end
    return c;
  endfunction

  // State registers
  logic [N-1:0]  pending_q, pending_d;
  logic [W-1:0]  out_q,     out_d;
  logic          valid_q,   valid_d;
  logic [CW-1:0] count_q,   count_d;
  logic          overflow_q, overflow_d;

  // Combinational helpers
  logic          take;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  req_in;
  logic [N-1:0]  kept;

  always_comb begin
    take     = valid_q & ack;
    clr_mask = take ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
    req_in   = en ? req : '0;
    kept     = pending_q & ~clr_mask;

    // The new request is ORed after the clear, so a request and a consume
    // of the same bit in one cycle leave that bit pending.
    pending_d = kept | req_in;

    // A presented index is locked until consumed: a newly arriving
    // higher-priority request must not swap out under the consumer.
    if (!valid_q || take) begin
      out_d = lowest_index(pending_d);
    end else begin
      out_d = out_q;
    end

    valid_d    = |pending_d;
    count_d    = popcount(pending_d);
    // Only bits that stay pending count as a collision; re-requesting the
    // bit being consumed this cycle is a legitimate re-arm.
    overflow_d = overflow_q | (|(req_in & kept));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pending_encoder_8to3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pending_encoder_8to3
//  Purpose  : Directed self-checking bench for pending_encoder_8to3. Each
//             step drives inputs, pushes the expected post-edge state to a
//             scoreboard queue, and pops/compares it one edge later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pending_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       ack;
  logic [2:0] out;
  logic       valid;
  logic [7:0] pending;
  logic [3:0] count;
  logic       overflow;

  int total;
  int bad;

  typedef struct {
    string      tag;
    logic [7:0] pend;
    logic       v;
    logic [2:0] o;
    logic [3:0] c;
    logic       ov;
  } exp_t;

  exp_t sb[$];

  pending_encoder_8to3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .ack      (ack),
    .out      (out),
    .valid    (valid),
    .pending  (pending),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 3-to-8 decoder feeding the loopback sweep.
  function automatic logic [7:0] dec3to8(input logic [2:0] sel, input logic den);
    logic [7:0] one;
    one = 8'h01;
    return den ? (one << sel) : 8'h00;
  endfunction

  task automatic check(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rn, input logic e,
                      input logic [7:0] r, input logic a,
                      input logic [7:0] ep, input logic ev, input logic [2:0] eo,
                      input logic [3:0] ec, input logic eov);
    exp_t x;
    x.tag = tag; x.pend = ep; x.v = ev; x.o = eo; x.c = ec; x.ov = eov;
    rst_n = rn; en = e; req = r; ack = a;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(x.tag, "pending",  pending,         x.pend);
    check(x.tag, "valid",    {7'd0, valid},   {7'd0, x.v});
    check(x.tag, "out",      {5'd0, out},     {5'd0, x.o});
    check(x.tag, "count",    {4'd0, count},   {4'd0, x.c});
    check(x.tag, "overflow", {7'd0, overflow},{7'd0, x.ov});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; en = 1'b0; req = 8'h00; ack = 1'b0;
    @(posedge clk);
    #1;

    // 1. Reset overrides en/req/ack
    step("reset",      0, 1, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 0);

    // 2. Single request then consume
    step("single_req", 1, 1, 8'h20, 0, 8'h20, 1, 3'd5, 4'd1, 0);
    step("single_ack", 1, 0, 8'h00, 1, 8'h00, 0, 3'd0, 4'd0, 0);

    // 3. Lock and priority
    step("lock_req90", 1, 1, 8'h90, 0, 8'h90, 1, 3'd4, 4'd2, 0);
    step("lock_hold",  1, 1, 8'h01, 0, 8'h91, 1, 3'd4, 4'd3, 0);
    step("lock_ack4",  1, 0, 8'h00, 1, 8'h81, 1, 3'd0, 4'd2, 0);
    step("lock_ack0",  1, 0, 8'h00, 1, 8'h80, 1, 3'd7, 4'd1, 0);
    step("lock_ack7",  1, 0, 8'h00, 1, 8'h00, 0, 3'd0, 4'd0, 0);
    step("idle_ack",   1, 0, 8'h00, 1, 8'h00, 0, 3'd0, 4'd0, 0);

    // 4. Simultaneous request and consume of the same bit
    step("sim_setup",  1, 1, 8'h08, 0, 8'h08, 1, 3'd3, 4'd1, 0);
    step("sim_reqack", 1, 1, 8'h08, 1, 8'h08, 1, 3'd3, 4'd1, 0);
    step("sim_drain",  1, 0, 8'h00, 1, 8'h00, 0, 3'd0, 4'd0, 0);

    // 5. Overflow (sticky) and enable gating
    step("ovf_setup",  1, 1, 8'h04, 0, 8'h04, 1, 3'd2, 4'd1, 0);
    step("ovf_hit",    1, 1, 8'h04, 0, 8'h04, 1, 3'd2, 4'd1, 1);
    step("ovf_drain",  1, 0, 8'h00, 1, 8'h00, 0, 3'd0, 4'd0, 1);
    step("gate_setup", 1, 1, 8'h10, 0, 8'h10, 1, 3'd4, 4'd1, 1);
    step("gate_en0",   1, 0, 8'hFF, 0, 8'h10, 1, 3'd4, 4'd1, 1);
    step("gate_drain", 1, 0, 8'hFF, 1, 8'h00, 0, 3'd0, 4'd0, 1);
    step("ovf_clear",  0, 0, 8'h00, 0, 8'h00, 0, 3'd0, 4'd0, 0);

    // 6. Loopback through a 3-to-8 decoder, with a reset mid-sweep
    for (int i = 0; i < 8; i++) begin
      step($sformatf("loop_req%0d", i), 1, 1, dec3to8(3'(i), 1'b1), 0,
           8'h01 << i, 1, 3'(i), 4'd1, 0);
      if (i == 4) begin
        step("loop_midrst", 0, 1, dec3to8(3'(i), 1'b1), 1,
             8'h00, 0, 3'd0, 4'd0, 0);
      end else begin
        step($sformatf("loop_ack%0d", i), 1, 0, 8'h00, 1,
             8'h00, 0, 3'd0, 4'd0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
